// File: rtl/fadd_pkg.sv
// Shared widths and constants for the binary32 adder normalize/round/pack stage.
// Flag bit positions apply only to builds with FADD_FLAGS_EN defined.
package fadd_pkg;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int MAG_W  = MAN_W + 4;
  localparam int LZ_W   = 5;
  localparam int FLAG_W = 3;

  localparam logic [EXP_W-1:0] BIAS    = 8'd127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  // Infinity without its sign bit
  localparam logic [EXP_W+MAN_W-1:0] QINF = {EXP_MAX, {MAN_W{1'b0}}};

  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;
endpackage

// File: rtl/fadd_lzc27.sv
// Leading-zero counter over the 26 magnitude bits below the carry position.
// The count is 0..25; zero is set when no bit is set.
module fadd_lzc27
  import fadd_pkg::*;
(
  input  logic [MAG_W-2:0] bits,
  output logic [LZ_W-1:0]  count,
  output logic             zero
);
  // lead[i] is set only for the most significant set bit
  logic [MAG_W-2:0] lead;

  generate
    for (genvar gi = 0; gi < MAG_W-1; gi++) begin : g_lead
      if (gi == MAG_W-2) begin : g_top
        assign lead[gi] = bits[gi];
      end else begin : g_rest
        assign lead[gi] = bits[gi] & ~(|bits[MAG_W-2:gi+1]);
      end
    end
  endgenerate

  assign zero = ~(|bits);

  always_comb begin
    count = '0;
    for (int i = 0; i < MAG_W-1; i++) begin
      if (lead[i]) count = count | LZ_W'(MAG_W-2-i);
    end
  end
endmodule

// File: rtl/fadd_norm_round.sv
// Two-stage normalize/round-to-nearest-even/pack stage of the binary32 adder.
// Defining FADD_FLAGS_EN adds the {overflow, underflow, inexact} out_flags port.
module fadd_norm_round
  import fadd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result
`ifdef FADD_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] out_flags
`endif
);
  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_TOP  = $signed({2'b00, EXP_MAX});

  logic             s2_load;
  logic             s1_load;
  logic             s1_valid_reg;
  logic             s1_sign_reg;
  logic             s1_sticky_reg;
  logic             s1_zero_reg;
  logic [EXP_W-1:0] s1_exp_reg;
  logic [MAG_W-1:0] s1_mag_reg;
  logic [LZ_W-1:0]  s1_lz_reg;
  logic [LZ_W-1:0]  lz_count;
  logic             lz_zero;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

  fadd_lzc27 u_lzc (
    .bits  (in_mag[MAG_W-2:0]),
    .count (lz_count),
    .zero  (lz_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (s1_load) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg   <= in_sign;
        s1_exp_reg    <= in_exp;
        s1_mag_reg    <= in_mag;
        s1_sticky_reg <= in_sticky;
        s1_lz_reg     <= lz_count;
        s1_zero_reg   <= !in_mag[MAG_W-1] && lz_zero;
      end
    end
  end

  logic [MAG_W-2:0]      shl;
  logic [MAN_W:0]        sig;
  logic [MAN_W+1:0]      sig_rnd;
  logic [MAN_W-1:0]      frac_rnd;
  logic                  g_bit;
  logic                  r_bit;
  logic                  s_bit;
  logic                  round_up;
  logic signed [XW-1:0]  exp_base;
  logic signed [XW-1:0]  exp_norm;
  logic signed [XW-1:0]  exp_rnd;
  logic                  is_inf_in;
  logic                  is_zero;
  logic                  is_flush;
  logic                  is_ovf;
  logic [31:0]           result_next;

  assign shl      = s1_mag_reg[MAG_W-2:0] << s1_lz_reg;
  assign exp_base = $signed({2'b00, s1_exp_reg});

  // A carry shifts the 24-bit significand right one place; otherwise left by lz
  always_comb begin
    if (s1_mag_reg[MAG_W-1]) begin
      sig      = s1_mag_reg[MAG_W-1:3];
      g_bit    = s1_mag_reg[2];
      r_bit    = s1_mag_reg[1];
      s_bit    = s1_mag_reg[0] | s1_sticky_reg;
      exp_norm = exp_base + XW'(1);
    end else begin
      sig      = shl[MAG_W-2:2];
      g_bit    = shl[1];
      r_bit    = shl[0];
      s_bit    = s1_sticky_reg;
      exp_norm = exp_base - $signed({{(XW-LZ_W){1'b0}}, s1_lz_reg});
    end
  end

  // Rounding past an all-ones significand renormalizes by one place
  assign round_up = g_bit & (r_bit | s_bit | sig[0]);
  assign sig_rnd  = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
  assign frac_rnd = sig_rnd[MAN_W+1] ? sig_rnd[MAN_W:1] : sig_rnd[MAN_W-1:0];
  assign exp_rnd  = exp_norm + $signed({{(XW-1){1'b0}}, sig_rnd[MAN_W+1]});

  assign is_inf_in = (s1_exp_reg == EXP_MAX);
  assign is_zero   = s1_zero_reg && !s1_sticky_reg;
  assign is_flush  = s1_zero_reg || (exp_norm <= EXP_ZERO);
  assign is_ovf    = (exp_rnd >= EXP_TOP);

  always_comb begin
    result_next = {s1_sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
    if (is_inf_in) begin
      result_next = {s1_sign_reg, QINF};
    end else if (is_zero) begin
      result_next = '0;
    end else if (is_flush) begin
      result_next = {s1_sign_reg, {(EXP_W+MAN_W){1'b0}}};
    end else if (is_ovf) begin
      result_next = {s1_sign_reg, QINF};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) out_result <= result_next;
    end
  end

`ifdef FADD_FLAGS_EN
  logic [FLAG_W-1:0] flags_next;

  always_comb begin
    flags_next = '0;
    if (!is_inf_in && !is_zero) begin
      if (is_flush) begin
        flags_next[FLAG_UNF] = 1'b1;
        flags_next[FLAG_INX] = 1'b1;
      end else if (is_ovf) begin
        flags_next[FLAG_OVF] = 1'b1;
        flags_next[FLAG_INX] = 1'b1;
      end else begin
        flags_next[FLAG_INX] = g_bit | r_bit | s_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= '0;
    end else if (s2_load && s1_valid_reg) begin
      out_flags <= flags_next;
    end
  end
`endif
endmodule

// File: tb/tb_fadd_norm_round.sv
// Bench for fadd_norm_round: directed corner cases, backpressure, mid-flight reset, then random
// traffic scored against a value-level rounding model. out_flags is checked when FADD_FLAGS_EN is set.
module tb_fadd_norm_round;
  import fadd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [26:0] in_mag = '0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
`ifdef FADD_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  logic [34:0] exp_q[$];
  bit          stall_prev = 1'b0;
  logic [31:0] held_result = '0;
  logic [2:0]  held_flags = '0;

  always #5 clk = ~clk;

  fadd_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mag     (in_mag),
    .in_sticky  (in_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef FADD_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  // Value view: bit 25 of mag weighs 2^(exp-BIAS); round the exact value to 24 significant bits
  function automatic logic [34:0] model(input logic sg, input logic [7:0] ex,
                                        input logic [26:0] m, input logic st);
    int          p;
    int          ue;
    longint      sig;
    longint      rem;
    longint      half;
    bit          up;
    bit          inexact;
    logic [2:0]  fl;
    fl = '0;
    if (ex == 8'hFF) return {3'b000, sg, 8'hFF, 23'h0};
    if (m == '0 && !st) return 35'h0;
    p = -1;
    for (int i = 0; i < 27; i++) if (m[i]) p = i;
    if (p < 0) begin
      fl[FLAG_UNF] = 1'b1;
      fl[FLAG_INX] = 1'b1;
      return {fl, sg, 31'h0};
    end
    ue = int'(ex) - int'(BIAS) + (p - 25);
    if (p >= 24) begin
      sig  = longint'(m) >> (p - 23);
      rem  = longint'(m) & ((longint'(1) << (p - 23)) - 1);
      half = longint'(1) << (p - 24);
    end else begin
      sig  = longint'(m) << (23 - p);
      rem  = 0;
      half = 1;
    end
    inexact = (rem != 0) || st;
    if (ue + int'(BIAS) <= 0) begin
      fl[FLAG_UNF] = 1'b1;
      fl[FLAG_INX] = 1'b1;
      return {fl, sg, 31'h0};
    end
    up = (rem > half) || (rem == half && (st || (sig % 2) == 1));
    sig = sig + longint'(up);
    if (sig == (longint'(1) << 24)) begin
      sig = longint'(1) << 23;
      ue++;
    end
    if (ue + int'(BIAS) >= 255) begin
      fl[FLAG_OVF] = 1'b1;
      fl[FLAG_INX] = 1'b1;
      return {fl, sg, 8'hFF, 23'h0};
    end
    fl[FLAG_INX] = inexact;
    return {fl, sg, 8'(ue + int'(BIAS)), 23'(sig)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock: drive, sample mid-cycle, score deliveries, enqueue accepted sums
  task automatic step(input logic v, input logic sg, input logic [7:0] ex, input logic [26:0] m,
                      input logic st, input logic ordy, input bit has_lit, input logic [34:0] lit,
                      output bit took);
    logic [34:0] want;
    in_valid  = v;
    in_sign   = sg;
    in_exp    = ex;
    in_mag    = m;
    in_sticky = st;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("hold_result", out_result, held_result);
`ifdef FADD_FLAGS_EN
      check("hold_flags", 32'(out_flags), 32'(held_flags));
`endif
    end
    took = v && in_ready;
    if (out_valid && ordy) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_output: observed %h expected no output", out_result);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("result", out_result, want[31:0]);
`ifdef FADD_FLAGS_EN
        check("flags", 32'(out_flags), 32'(want[34:32]));
`endif
      end
    end
    if (took) exp_q.push_back(has_lit ? lit : model(sg, ex, m, st));
    stall_prev  = out_valid && !ordy;
    held_result = out_result;
`ifdef FADD_FLAGS_EN
    held_flags  = out_flags;
`endif
    @(negedge clk);
  endtask

  task automatic drain();
    bit t;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(0, 0, '0, '0, 0, 1, 0, '0, t);
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic directed(input string tag, input logic sg, input logic [7:0] ex,
                          input logic [26:0] m, input logic st, input logic [34:0] lit);
    bit t;
    step(1, sg, ex, m, st, 1, 1, lit, t);
    check({tag, "_accept"}, 32'(t), 32'd1);
    drain();
  endtask

  initial begin
    bit          t;
    int          acc;
    int          idx;
    logic [7:0]  bp_exp [3];
    logic [26:0] bp_mag [3];
    logic        r_sg;
    logic        r_st;
    logic [7:0]  r_ex;
    logic [26:0] r_m;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_result", out_result, 32'h0);
`ifdef FADD_FLAGS_EN
    check("reset_out_flags", 32'(out_flags), 32'd0);
`endif
    @(negedge clk);

    // 1.0 + 1.0 with a two-cycle latency check
    step(1, 0, 8'd127, 27'h4000000, 0, 1, 1, {3'b000, 32'h40000000}, t);
    check("lat_accept", 32'(t), 32'd1);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    step(0, 0, '0, '0, 0, 1, 0, '0, t);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    drain();

    directed("cancel",   0, 8'd127, 27'h0000004, 0, {3'b000, 32'h34000000});
    directed("tie_odd",  0, 8'd127, 27'h2000006, 0, {3'b001, 32'h3F800002});
    directed("tie_even", 0, 8'd127, 27'h2000002, 0, {3'b001, 32'h3F800000});
    directed("ovf",      0, 8'd254, 27'h4000000, 0, {3'b101, 32'h7F800000});
    directed("unf",      0, 8'd1,   27'h0000004, 0, {3'b011, 32'h00000000});
    directed("inf_in",   1, 8'd255, 27'h2345678, 1, {3'b000, 32'hFF800000});
    directed("zero",     1, 8'd90,  27'h0000000, 0, {3'b000, 32'h00000000});
    directed("rnd_carry", 1, 8'd127, 27'h3FFFFFE, 0, {3'b001, 32'hC0000000});

    // Backpressure: three distinct sums offered while downstream stalls for six cycles
    bp_exp[0] = 8'd120; bp_mag[0] = 27'h2ABCDE4;
    bp_exp[1] = 8'd131; bp_mag[1] = 27'h5123457;
    bp_exp[2] = 8'd140; bp_mag[2] = 27'h0013579;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(idx < 3, 0, bp_exp[idx % 3], bp_mag[idx % 3], 1, 0, 0, '0, t);
      if (t) begin
        acc++;
        idx++;
      end
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 10 && idx < 3; c++) begin
      step(1, 0, bp_exp[idx], bp_mag[idx], 1, 1, 0, '0, t);
      if (t) idx++;
    end
    check("bp_all_taken", 32'(idx), 32'd3);
    drain();

    // Reset with both stages full: nothing in flight may emerge afterwards
    step(1, 0, 8'd130, 27'h2345678, 0, 0, 0, '0, t);
    step(1, 1, 8'd100, 27'h1111111, 0, 0, 0, '0, t);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step(0, 0, '0, '0, 0, 0, 0, '0, t);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (6) step(0, 0, '0, '0, 0, 1, 0, '0, t);

    // Random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      r_sg = 1'($urandom);
      r_st = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       r_m = {1'b1, 26'($urandom)};
        1:       r_m = {2'b01, 25'($urandom)};
        2:       r_m = 27'($urandom) >> $urandom_range(0, 26);
        default: r_m = 27'($urandom_range(0, 15));
      endcase
      case ($urandom_range(0, 9))
        0:       r_ex = 8'($urandom);
        1:       r_ex = 8'($urandom_range(250, 255));
        2:       r_ex = 8'($urandom_range(0, 26));
        default: r_ex = 8'($urandom_range(100, 154));
      endcase
      step($urandom_range(0, 3) != 0, r_sg, r_ex, r_m, r_st, $urandom_range(0, 9) < 7, 0, '0, t);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
